// File: rtl/spi_ad5628_rx.sv
// AD5628 SPI responder: oversamples sclk/mosi/cs, captures frames,
// and keeps a register image of the DAC.
module spi_ad5628_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter bit SAMPLE_FALLING = 1'b1,
    parameter int FRAME_BITS     = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sclk,
    input  logic        mosi,
    input  logic        cs,
    output logic        frame_valid,
    output logic        frame_err,
    output logic [31:0] frame_data,
    output logic [7:0]  frame_cnt,
    output logic [95:0] dac_code,
    output logic [7:0]  pd_mask,
    output logic [7:0]  ldac_mask,
    output logic        ref_on,
    output logic [1:0]  clear_code
);

    localparam int CW = $clog2(FRAME_BITS + 2);

    typedef enum logic [1:0] {IDLE, SHIFT, DECODE} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sclk_s, mosi_s, cs_s;
    logic [31:0]            sr;
    logic [CW-1:0]          cnt;
    logic                   fall_pend;
    logic [11:0]            in_reg [8];
    logic [11:0]            dac    [8];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sclk_s <= '0;
            mosi_s <= '0;
            cs_s   <= '1;
        end else begin
            sclk_s <= {sclk_s[SYNC_STAGES-2:0], sclk};
            mosi_s <= {mosi_s[SYNC_STAGES-2:0], mosi};
            cs_s   <= {cs_s[SYNC_STAGES-2:0], cs};
        end
    end

    logic sclk_o, sclk_n, cs_o, cs_n, mosi_b;
    logic smp, cs_fall, cs_rise;

    assign sclk_o  = sclk_s[SYNC_STAGES-1];
    assign sclk_n  = sclk_s[SYNC_STAGES-2];
    assign cs_o    = cs_s[SYNC_STAGES-1];
    assign cs_n    = cs_s[SYNC_STAGES-2];
    assign mosi_b  = mosi_s[SYNC_STAGES-2];
    assign smp     = SAMPLE_FALLING ? (sclk_o & ~sclk_n)
                                    : (~sclk_o & sclk_n);
    assign cs_fall = cs_o & ~cs_n;
    assign cs_rise = ~cs_o & cs_n;

    logic [3:0]  cmd, addr;
    logic [11:0] data;
    logic [7:0]  feat, sel;
    logic        addr_ok, good;

    always_comb begin
        cmd     = sr[27:24];
        addr    = sr[23:20];
        data    = sr[19:8];
        feat    = sr[7:0];
        sel     = (addr == 4'hF) ? 8'hFF : (8'h1 << addr[2:0]);
        addr_ok = ~addr[3] | (addr == 4'hF);
        good    = (cnt == CW'(FRAME_BITS)) && (cmd <= 4'd8)
                  && ((cmd >= 4'd4) || addr_ok);
    end

    always_comb begin
        dac_code = '0;
        for (int i = 0; i < 8; i++) dac_code[i*12 +: 12] = dac[i];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            sr          <= '0;
            cnt         <= '0;
            fall_pend   <= 1'b0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            frame_data  <= '0;
            frame_cnt   <= '0;
            pd_mask     <= '0;
            ldac_mask   <= '0;
            ref_on      <= 1'b0;
            clear_code  <= '0;
            for (int i = 0; i < 8; i++) begin
                in_reg[i] <= '0;
                dac[i]    <= '0;
            end
        end else begin
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cs_fall || fall_pend) begin
                        state     <= SHIFT;
                        cnt       <= '0;
                        sr        <= '0;
                        fall_pend <= 1'b0;
                    end
                end
                SHIFT: begin
                    // a sample coinciding with cs rising is still counted
                    if (smp) begin
                        sr <= {sr[30:0], mosi_b};
                        if (cnt != CW'(FRAME_BITS + 1))
                            cnt <= cnt + CW'(1);
                    end
                    if (cs_rise) state <= DECODE;
                end
                DECODE: begin
                    state      <= IDLE;
                    fall_pend  <= cs_fall;
                    frame_data <= sr;
                    if (!good) begin
                        frame_err <= 1'b1;
                    end else begin
                        frame_valid <= 1'b1;
                        frame_cnt   <= frame_cnt + 8'd1;
                        unique case (cmd)
                            4'd0: for (int i = 0; i < 8; i++)
                                if (sel[i]) begin
                                    in_reg[i] <= data;
                                    if (ldac_mask[i]) dac[i] <= data;
                                end
                            4'd1: for (int i = 0; i < 8; i++)
                                if (sel[i]) dac[i] <= in_reg[i];
                            4'd2: for (int i = 0; i < 8; i++) begin
                                if (sel[i]) in_reg[i] <= data;
                                dac[i] <= sel[i] ? data : in_reg[i];
                            end
                            4'd3: for (int i = 0; i < 8; i++)
                                if (sel[i]) begin
                                    in_reg[i] <= data;
                                    dac[i]    <= data;
                                end
                            4'd4: pd_mask <= (sr[9:8] == 2'b00)
                                             ? (pd_mask & ~feat)
                                             : (pd_mask | feat);
                            4'd5: clear_code <= sr[1:0];
                            4'd6: ldac_mask  <= feat;
                            4'd7: begin
                                pd_mask    <= '0;
                                ldac_mask  <= '0;
                                ref_on     <= 1'b0;
                                clear_code <= '0;
                                for (int i = 0; i < 8; i++) begin
                                    in_reg[i] <= '0;
                                    dac[i]    <= '0;
                                end
                            end
                            default: ref_on <= sr[0];
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_ad5628_rx.sv
// Bench for spi_ad5628_rx: directed and random frames checked
// against a behavioural model of the AD5628 register file.
module tb_spi_ad5628_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        sclk = 1'b1;
    logic        mosi = 1'b0;
    logic        cs = 1'b1;
    logic        frame_valid, frame_err, ref_on;
    logic [31:0] frame_data;
    logic [7:0]  frame_cnt, pd_mask, ldac_mask;
    logic [95:0] dac_code;
    logic [1:0]  clear_code;

    spi_ad5628_rx dut (
        .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .cs(cs),
        .frame_valid(frame_valid), .frame_err(frame_err),
        .frame_data(frame_data), .frame_cnt(frame_cnt),
        .dac_code(dac_code), .pd_mask(pd_mask),
        .ldac_mask(ldac_mask), .ref_on(ref_on),
        .clear_code(clear_code)
    );

    always #10 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    logic [11:0] m_in [8];
    logic [11:0] m_dac [8];
    logic [7:0]  m_pd, m_ldac, m_cnt;
    logic        m_ref;
    logic [1:0]  m_clr;
    logic [31:0] m_data;

    task automatic chk(input string tag, input logic [95:0] obs,
                       input logic [95:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] m_code();
        logic [95:0] c = '0;
        for (int i = 0; i < 8; i++) c[i*12 +: 12] = m_dac[i];
        return c;
    endfunction

    task automatic m_clear_regs();
        for (int i = 0; i < 8; i++) begin
            m_in[i]  = '0;
            m_dac[i] = '0;
        end
        m_pd = '0; m_ldac = '0; m_ref = 1'b0; m_clr = '0;
    endtask

    // kind: 1 = valid frame, 2 = error frame
    task automatic m_frame(input logic [63:0] w, input int n,
                           output int kind);
        logic [31:0] f;
        logic [3:0]  c, a;
        logic [11:0] d;
        bit          ch [8];
        f = (n >= 32) ? w[31:0] : (w[31:0] & ~(32'hFFFF_FFFF << n));
        m_data = f;
        c = f[27:24]; a = f[23:20]; d = f[19:8];
        for (int i = 0; i < 8; i++) ch[i] = (a == 15) || (a == i);
        kind = 1;
        if (n != 32 || c > 8 || (c < 4 && a > 7 && a != 15)) kind = 2;
        if (kind == 1) begin
            m_cnt++;
            case (c)
                0: for (int i = 0; i < 8; i++) if (ch[i]) begin
                       m_in[i] = d;
                       if (m_ldac[i]) m_dac[i] = d;
                   end
                1: for (int i = 0; i < 8; i++)
                       if (ch[i]) m_dac[i] = m_in[i];
                2: begin
                       for (int i = 0; i < 8; i++) if (ch[i]) m_in[i] = d;
                       for (int i = 0; i < 8; i++) m_dac[i] = m_in[i];
                   end
                3: for (int i = 0; i < 8; i++) if (ch[i]) begin
                       m_in[i] = d; m_dac[i] = d;
                   end
                4: m_pd = (f[9:8] == 0) ? (m_pd & ~f[7:0])
                                        : (m_pd | f[7:0]);
                5: m_clr = f[1:0];
                6: m_ldac = f[7:0];
                7: m_clear_regs();
                default: m_ref = f[0];
            endcase
        end
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "/data"}, 96'(frame_data), 96'(m_data));
        chk({tag, "/cnt"},  96'(frame_cnt),  96'(m_cnt));
        chk({tag, "/dac"},  dac_code,        m_code());
        chk({tag, "/pd"},   96'(pd_mask),    96'(m_pd));
        chk({tag, "/ldac"}, 96'(ldac_mask),  96'(m_ldac));
        chk({tag, "/ref"},  96'(ref_on),     96'(m_ref));
        chk({tag, "/clr"},  96'(clear_code), 96'(m_clr));
    endtask

    task automatic send(input logic [63:0] w, input int n,
                        output int kind, output int lat);
        @(negedge clk);
        cs = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = n - 1; i >= 0; i--) begin
            mosi = w[i];
            repeat (4) @(negedge clk);
            sclk = 1'b0;
            repeat (8) @(negedge clk);
            sclk = 1'b1;
            repeat (4) @(negedge clk);
        end
        cs = 1'b1;
        kind = 0;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (frame_valid || frame_err) begin
                lat = k;
                kind = frame_valid ? (frame_err ? 3 : 1) : 2;
                break;
            end
        end
    endtask

    task automatic run(input logic [63:0] w, input int n,
                       input string tag);
        int k, lat, ek;
        send(w, n, k, lat);
        m_frame(w, n, ek);
        chk({tag, "/kind"}, 96'(k), 96'(ek));
        chk({tag, "/lat"}, 96'(lat), 96'd3);
        @(negedge clk);
        chk({tag, "/pulse"}, 96'({frame_valid, frame_err}), 96'd0);
        chk_state(tag);
    endtask

    initial begin
        m_clear_regs();
        m_cnt = '0;
        m_data = '0;
        repeat (3) @(negedge clk);
        chk_state("reset");
        rst = 1'b1;
        repeat (4) @(negedge clk);

        run(64'hF800_0001, 32, "ref");
        run(64'hF400_00FF, 32, "pwr");
        run(64'hF600_0000, 32, "ldac0");
        chk("ref_on1", 96'(ref_on), 96'd1);
        chk("cnt3", 96'(frame_cnt), 96'd3);

        run(64'hF304_CC00, 32, "wrA");
        run(64'hF326_6600, 32, "wrC");
        chk("chA", 96'(dac_code[11:0]), 96'h4CC);
        chk("chC", 96'(dac_code[35:24]), 96'h666);

        run(64'hF0F8_0000, 32, "wr_all_noldac");
        run(64'hF120_0000, 32, "copyC");
        chk("chC800", 96'(dac_code[35:24]), 96'h800);
        run(64'hF600_00FF, 32, "ldacFF");
        run(64'hF0F1_2300, 32, "wr_all_ldac");
        chk("all123", dac_code, {8{12'h123}});

        run(64'hF304_CC00 >> 12, 20, "short20");
        run(64'h1_F355_5500, 33, "long33");
        run(64'h0, 0, "zero");
        run(64'hF355_5500, 32, "good_after");

        run(64'hF391_2300, 32, "bad_addr");
        run(64'hFA00_0000, 32, "bad_cmd");
        run(64'hF500_0003, 32, "clr");
        run(64'hF7000000, 32, "swreset");

        run(64'hF800_0001, 32, "pre_rst_ref");
        run(64'hF301_2300, 32, "pre_rst_wr");
        @(negedge clk);
        cs = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 31; i >= 16; i--) begin
            mosi = 1'(32'hF3AB_CD00 >> i);
            repeat (4) @(negedge clk);
            sclk = 1'b0;
            repeat (8) @(negedge clk);
            sclk = 1'b1;
            repeat (4) @(negedge clk);
        end
        rst = 1'b0;
        #1;
        chk("rst_dac", dac_code, 96'h0);
        chk("rst_misc", 96'({frame_valid, frame_err, frame_data,
                             frame_cnt, pd_mask, ldac_mask, ref_on,
                             clear_code}), 96'h0);
        m_clear_regs();
        m_cnt = '0;
        m_data = '0;
        cs = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        run(64'hF371_2300, 32, "after_rst");
        chk("chH", 96'(dac_code[95:84]), 96'h123);

        for (int it = 0; it < 40; it++) begin
            logic [3:0]  c, a;
            logic [31:0] f;
            logic [63:0] w;
            int          n;
            c = 4'($urandom_range(0, 10));
            if (c == 10) c = 4'($urandom_range(9, 15));
            if (c == 7 && $urandom_range(0, 3) != 0) c = 4'd3;
            a = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 7))
                                           : 4'($urandom_range(8, 15));
            f = {4'($urandom), c, a, 12'($urandom), 8'($urandom)};
            w = {32'h0, f};
            n = 32;
            case ($urandom_range(0, 11))
                0: n = 0;
                1: n = 31;
                2: begin n = 33; w = {31'h0, 1'($urandom), f}; end
                default: n = 32;
            endcase
            run(w, n, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vecs, errs);
        $finish;
    end

endmodule
